// File: rtl/fir_coef_ctrl.sv
// Coefficient loader and swap sequencer for the 11-tap FIR.
// A new coefficient set is collected word by word into a shadow bank.
// It is copied into the active b bus only after the sample stream has
// been idle long enough to drain the FIR pipeline. An optional zero
// flush then clears the FIR delay line.
module fir_coef_ctrl #(
  parameter int NB       = 11,
  parameter int N_TAPS   = 11,
  parameter int LAT      = 2,
  parameter bit FLUSH_EN = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 CFG_START,
  input  logic                 CFG_VALID,
  input  logic [NB-1:0]        CFG_DATA,
  output logic                 CFG_READY,
  input  logic [NB-1:0]        DIN_UP,
  input  logic                 VIN_UP,
  output logic [NB-1:0]        DIN,
  output logic                 VIN,
  output logic [0:N_TAPS*NB-1] b,
  output logic                 HOLD,
  output logic                 BUSY,
  output logic                 CFG_DONE,
  output logic                 ERR
);

  localparam int WW = $clog2(N_TAPS + 1);
  localparam int IW = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam int FW = (N_TAPS < 3) ? 1 : $clog2(N_TAPS);

  localparam logic [WW-1:0] WIDX_ZERO = WW'(0);
  localparam logic [WW-1:0] WIDX_ONE  = WW'(1);
  localparam logic [WW-1:0] WIDX_LAST = WW'(N_TAPS - 1);
  localparam logic [WW-1:0] WIDX_MAX  = WW'(N_TAPS);
  localparam logic [IW-1:0] ICNT_ZERO = IW'(0);
  localparam logic [IW-1:0] ICNT_ONE  = IW'(1);
  localparam logic [IW-1:0] ICNT_MAX  = IW'(LAT);
  localparam logic [FW-1:0] FCNT_ZERO = FW'(0);
  localparam logic [FW-1:0] FCNT_ONE  = FW'(1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(N_TAPS - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [WW-1:0]          widx_r;
  logic [WW-1:0]          widx_s;
  logic [IW-1:0]          icnt_r;
  logic [IW-1:0]          icnt_s;
  logic [FW-1:0]          fcnt_r;
  logic [FW-1:0]          fcnt_s;
  logic                   accept_s;
  logic                   swap_s;
  logic                   err_s;
  logic [NB-1:0]          shadow_r [N_TAPS];
  logic [0:N_TAPS*NB-1]   b_r;
  logic [NB-1:0]          din_r;
  logic                   vin_r;
  logic                   cfg_ready_r;
  logic                   hold_r;
  logic                   busy_r;
  logic                   cfg_done_r;
  logic                   err_r;

  // Next state, counter updates and the accept/swap strobes
  always_comb begin
    state_s  = state_r;
    widx_s   = widx_r;
    icnt_s   = icnt_r;
    fcnt_s   = fcnt_r;
    accept_s = 1'b0;
    swap_s   = 1'b0;
    case (state_r)
      IDLE: begin
        icnt_s = ICNT_ZERO;
        fcnt_s = FCNT_ZERO;
        if (CFG_START) begin
          state_s = LOAD;
          widx_s  = WIDX_ZERO;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (CFG_VALID && cfg_ready_r) begin
          accept_s = 1'b1;
          if (widx_r != WIDX_MAX) begin
            widx_s = widx_r + WIDX_ONE;
          end else begin
            widx_s = widx_r;
          end
          if (widx_r == WIDX_LAST) begin
            state_s = ARMED;
            icnt_s  = ICNT_ZERO;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end
      ARMED: begin
        // Any upstream sample restarts the idle-run measurement
        if (VIN_UP) begin
          icnt_s = ICNT_ZERO;
        end else if (icnt_r != ICNT_MAX) begin
          icnt_s = icnt_r + ICNT_ONE;
        end else begin
          icnt_s = icnt_r;
        end
        if (icnt_s == ICNT_MAX) begin
          swap_s  = 1'b1;
          state_s = FLUSH_EN ? FLUSH : IDLE;
          fcnt_s  = FCNT_ZERO;
        end else begin
          state_s = ARMED;
        end
      end
      FLUSH: begin
        if (fcnt_r == FCNT_LAST) begin
          state_s = IDLE;
          fcnt_s  = FCNT_ZERO;
        end else begin
          state_s = FLUSH;
          fcnt_s  = fcnt_r + FCNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Protocol violations: restart request while busy, or a sample arriving during flush
  assign err_s = (CFG_START && (state_r != IDLE)) || (VIN_UP && (state_r == FLUSH));

  // State and counter registers
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_r <= IDLE;
      widx_r  <= WIDX_ZERO;
      icnt_r  <= ICNT_ZERO;
      fcnt_r  <= FCNT_ZERO;
    end else begin
      state_r <= state_s;
      widx_r  <= widx_s;
      icnt_r  <= icnt_s;
      fcnt_r  <= fcnt_s;
    end
  end

  // Shadow bank collects the incoming set; first accepted word is b0
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      for (int i = 0; i < N_TAPS; i++) begin
        shadow_r[i] <= {NB{1'b0}};
      end
    end else if (accept_s) begin
      shadow_r[widx_r] <= CFG_DATA;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Active bank changes only on the swap edge so the FIR never sees a mixed set
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      b_r <= {(N_TAPS*NB){1'b0}};
    end else if (swap_s) begin
      for (int i = 0; i < N_TAPS; i++) begin
        b_r[i*NB +: NB] <= shadow_r[i];
      end
    end else begin
      b_r <= b_r;
    end
  end

  // Sample path: zero-valued flush samples, drop anything arriving mid-flush, else pass through
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      din_r <= {NB{1'b0}};
      vin_r <= 1'b0;
    end else if (state_s == FLUSH) begin
      din_r <= {NB{1'b0}};
      vin_r <= 1'b1;
    end else if (state_r == FLUSH) begin
      din_r <= {NB{1'b0}};
      vin_r <= 1'b0;
    end else begin
      din_r <= DIN_UP;
      vin_r <= VIN_UP;
    end
  end

  // Status flags registered from the upcoming state so they line up with it
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      cfg_ready_r <= 1'b0;
      hold_r      <= 1'b0;
      busy_r      <= 1'b0;
      cfg_done_r  <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      cfg_ready_r <= (state_s == LOAD);
      hold_r      <= (state_s == ARMED) || (state_s == FLUSH);
      busy_r      <= (state_s != IDLE);
      cfg_done_r  <= swap_s;
      err_r       <= err_s;
    end
  end

  assign CFG_READY = cfg_ready_r;
  assign DIN       = din_r;
  assign VIN       = vin_r;
  assign b         = b_r;
  assign HOLD      = hold_r;
  assign BUSY      = busy_r;
  assign CFG_DONE  = cfg_done_r;
  assign ERR       = err_r;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed and randomized bench for fir_coef_ctrl with a queue-based
// reference model of the swap timing and the active coefficient bank.
module tb_fir_coef_ctrl;

  localparam int NB       = 11;
  localparam int N_TAPS   = 11;
  localparam int LAT      = 2;
  localparam bit FLUSH_EN = 1'b1;
  localparam int BW       = N_TAPS * NB;

  logic            CLK = 1'b0;
  logic            RST_n;
  logic            CFG_START;
  logic            CFG_VALID;
  logic [NB-1:0]   CFG_DATA;
  logic            CFG_READY;
  logic [NB-1:0]   DIN_UP;
  logic            VIN_UP;
  logic [NB-1:0]   DIN;
  logic            VIN;
  logic [0:BW-1]   b;
  logic            HOLD;
  logic            BUSY;
  logic            CFG_DONE;
  logic            ERR;

  int total = 0;
  int bad   = 0;

  logic [NB-1:0] coef [N_TAPS];   // set currently being loaded
  logic [BW-1:0] exp_b;           // model of the active bank

  always #5 CLK = ~CLK;

  fir_coef_ctrl #(
    .NB(NB), .N_TAPS(N_TAPS), .LAT(LAT), .FLUSH_EN(FLUSH_EN)
  ) dut (
    .CLK(CLK), .RST_n(RST_n),
    .CFG_START(CFG_START), .CFG_VALID(CFG_VALID), .CFG_DATA(CFG_DATA),
    .CFG_READY(CFG_READY),
    .DIN_UP(DIN_UP), .VIN_UP(VIN_UP), .DIN(DIN), .VIN(VIN),
    .b(b), .HOLD(HOLD), .BUSY(BUSY), .CFG_DONE(CFG_DONE), .ERR(ERR)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // b0 occupies the leftmost bits of the bus, so append taps in order
  function automatic logic [BW-1:0] bank_of();
    logic [BW-1:0] v;
    v = {BW{1'b0}};
    for (int i = 0; i < N_TAPS; i++) begin
      v = (v << NB) | {{(BW-NB){1'b0}}, coef[i]};
    end
    return v;
  endfunction

  task automatic passthru(input int n);
    logic [NB-1:0] d;
    logic          v;
    for (int i = 0; i < n; i++) begin
      d = NB'($urandom);
      v = 1'($urandom_range(0, 1));
      DIN_UP = d;
      VIN_UP = v;
      step();
      check("pass_din", DIN, d);
      check("pass_vin", VIN, v);
    end
    VIN_UP = 1'b0;
  endtask

  task automatic load_set(input int n, input bit start_with_valid, input int err_k);
    CFG_START = 1'b1;
    CFG_VALID = start_with_valid;
    CFG_DATA  = 11'h555;
    step();
    CFG_START = 1'b0;
    CFG_VALID = 1'b0;
    check("start_ready", CFG_READY, 1'b1);
    check("start_busy", BUSY, 1'b1);
    check("start_err", ERR, 1'b0);
    for (int k = 0; k < n; k++) begin
      CFG_VALID = 1'b1;
      CFG_DATA  = coef[k];
      CFG_START = (k == err_k);
      step();
      check("load_err", ERR, (k == err_k));
    end
    CFG_VALID = 1'b0;
    CFG_START = 1'b0;
    if (n == N_TAPS) begin
      check("load_ready_drop", CFG_READY, 1'b0);
      check("load_hold", HOLD, 1'b1);
    end
  endtask

  // Swap is expected on the first edge where the last LAT samples seen in ARMED were all idle
  task automatic armed_run(input logic [15:0] pat, input int plen);
    logic          hist[$];
    logic          done_exp;
    logic [BW-1:0] new_b;
    new_b = bank_of();
    hist.delete();
    for (int c = 0; c < 40; c++) begin
      if (c < plen) VIN_UP = pat[plen-1-c];
      else          VIN_UP = 1'b0;
      DIN_UP = NB'($urandom);
      step();
      hist.push_back(VIN_UP);
      done_exp = 1'b1;
      if (hist.size() < LAT) done_exp = 1'b0;
      else for (int t = 1; t <= LAT; t++) if (hist[hist.size()-t] == 1'b1) done_exp = 1'b0;
      check("armed_done", CFG_DONE, done_exp);
      check("armed_hold", HOLD, 1'b1);
      if (done_exp) exp_b = new_b;
      check("armed_b", b, exp_b);
      if (done_exp) break;
    end
    VIN_UP = 1'b0;
  endtask

  task automatic flush_run(input int err_idx);
    for (int j = 0; j < N_TAPS - 1; j++) begin
      check("flush_vin", VIN, 1'b1);
      check("flush_din", DIN, {NB{1'b0}});
      check("flush_hold", HOLD, 1'b1);
      check("flush_done", CFG_DONE, (j == 0));
      VIN_UP = (j == err_idx);
      DIN_UP = NB'($urandom) | 11'h001;
      step();
      check("flush_err", ERR, (j == err_idx));
    end
    VIN_UP = 1'b0;
    check("flush_end_hold", HOLD, 1'b0);
    check("flush_end_busy", BUSY, 1'b0);
    check("flush_end_vin", VIN, 1'b0);
    check("flush_end_b", b, exp_b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_n = 1'b0; CFG_START = 1'b1; CFG_VALID = 1'b0; CFG_DATA = 11'h000;
    DIN_UP = 11'h2AA; VIN_UP = 1'b1;
    exp_b = {BW{1'b0}};
    repeat (3) step();
    check("rst_b", b, {BW{1'b0}});
    check("rst_din", DIN, {NB{1'b0}});
    check("rst_vin", VIN, 1'b0);
    check("rst_ready", CFG_READY, 1'b0);
    check("rst_hold", HOLD, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", CFG_DONE, 1'b0);
    check("rst_err", ERR, 1'b0);

    RST_n = 1'b1; CFG_START = 1'b0; VIN_UP = 1'b0; DIN_UP = 11'h000;
    step();
    check("idle_busy", BUSY, 1'b0);
    check("idle_ready", CFG_READY, 1'b0);

    DIN_UP = 11'h3FF; VIN_UP = 1'b1;
    step();
    check("pass_3ff", DIN, 11'h3FF);
    check("pass_3ff_vin", VIN, 1'b1);
    DIN_UP = 11'h401;
    step();
    check("pass_401", DIN, 11'h401);
    DIN_UP = 11'h000; VIN_UP = 1'b0;
    step();
    passthru(20);

    // Words 1..11, the start cycle also carries a valid word that must be ignored
    for (int i = 0; i < N_TAPS; i++) coef[i] = NB'(i + 1);
    load_set(N_TAPS, 1'b1, -1);
    armed_run(16'h0000, 0);
    check("b0_is_1", b[0:10], 11'd1);
    check("b10_is_11", b[110:120], 11'd11);
    flush_run(-1);

    // Delayed swap with restart attempt mid-load and a sample mid-flush
    for (int i = 0; i < N_TAPS; i++) coef[i] = NB'($urandom);
    load_set(N_TAPS, 1'b0, 5);
    armed_run(16'b10100, 5);
    flush_run(2);
    passthru(4);

    // Random coefficient sets with random idle patterns
    repeat (3) begin
      for (int i = 0; i < N_TAPS; i++) coef[i] = NB'($urandom);
      load_set(N_TAPS, 1'($urandom_range(0, 1)), -1);
      armed_run(16'($urandom), $urandom_range(0, 8));
      flush_run(-1);
      passthru(5);
    end

    // Reset in the middle of a load clears the active bank
    for (int i = 0; i < N_TAPS; i++) coef[i] = NB'($urandom);
    load_set(6, 1'b0, -1);
    RST_n = 1'b0;
    step();
    RST_n = 1'b1;
    exp_b = {BW{1'b0}};
    check("midrst_b", b, {BW{1'b0}});
    check("midrst_busy", BUSY, 1'b0);
    check("midrst_ready", CFG_READY, 1'b0);

    for (int i = 0; i < N_TAPS; i++) coef[i] = 11'h7FF;
    load_set(N_TAPS, 1'b0, -1);
    armed_run(16'h0000, 0);
    flush_run(-1);
    check("all_7ff", b, {N_TAPS{11'h7FF}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
